imem_arb: RTL

Arbiter and sequencer for the core's single shared memory port. Two requesters use the port: instruction fetch (the read stage) and the load/store unit. Only one transaction is outstanding at a time, and each response is routed back to the requester that issued it. The block sits between the fetch/LSU stages and the memory bus; it has LSU priority with a starvation guard for fetch and a flush-driven discard of in-flight fetch data.

---
 rtl/imem_arb.sv | 127 ++++++++++++
 1 files changed

// File: rtl/imem_arb.sv
// Shared memory-port arbiter for instruction fetch and the load/store unit.
// One transaction in flight; LSU has priority, with a streak limit so fetch cannot starve.
module imem_arb #(
  parameter int MAX_LS_STREAK = 4,
  parameter int AW            = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          if_req_val,
  output logic          if_req_rdy,
  input  logic [AW-1:0] if_addr,
  output logic          if_rsp_val,
  output logic [31:0]   if_rsp_data,
  input  logic          ls_req_val,
  output logic          ls_req_rdy,
  input  logic [AW-1:0] ls_addr,
  input  logic          ls_wen,
  input  logic [31:0]   ls_wdata,
  input  logic [3:0]    ls_wstrb,
  output logic          ls_rsp_val,
  output logic [31:0]   ls_rsp_data,
  output logic          mem_req_val,
  input  logic          mem_req_rdy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic          mem_rsp_val,
  input  logic [31:0]   mem_rsp_data
);

  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_LS} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wen;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
  } mem_req_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_LS_STREAK);

  state_t     state, state_nxt;
  logic [3:0] streak, streak_nxt;
  logic       drop, drop_nxt;
  logic       if_ok, sel_ls, sel_if;
  mem_req_t   req;

  assign if_ok = if_req_val & ~flush;

  always_comb begin
    state_nxt   = state;
    streak_nxt  = streak;
    drop_nxt    = drop;
    sel_ls      = 1'b0;
    sel_if      = 1'b0;
    req         = '0;
    mem_req_val = 1'b0;
    if_req_rdy  = 1'b0;
    ls_req_rdy  = 1'b0;
    if_rsp_val  = 1'b0;
    ls_rsp_val  = 1'b0;
    case (state)
      IDLE: begin
        drop_nxt = 1'b0;
        // Gate on rst so nothing is offered to the bus while held in reset.
        if (!rst) begin
          sel_ls = ls_req_val & ~(if_ok & (streak == MAX_CNT));
          sel_if = if_ok & ~sel_ls;
        end
        mem_req_val = sel_ls | sel_if;
        if (sel_ls) req = '{addr: ls_addr, wen: ls_wen, wdata: ls_wdata, wstrb: ls_wstrb};
        else if (sel_if) req = '{addr: if_addr, wen: 1'b0, wdata: 32'h0, wstrb: 4'h0};
        if_req_rdy = sel_if & mem_req_rdy;
        ls_req_rdy = sel_ls & mem_req_rdy;
        if (mem_req_val && mem_req_rdy) begin
          if (sel_ls) begin
            state_nxt = WAIT_LS;
            if (if_req_val) streak_nxt = (streak == MAX_CNT) ? streak : streak + 4'd1;
            else            streak_nxt = 4'd0;
          end else begin
            state_nxt  = WAIT_IF;
            streak_nxt = 4'd0;
          end
        end
      end
      WAIT_IF: begin
        if (mem_rsp_val) begin
          // A flush in the same cycle as the data still kills it.
          if_rsp_val = ~drop & ~flush;
          drop_nxt   = 1'b0;
          state_nxt  = IDLE;
        end else if (flush) begin
          drop_nxt = 1'b1;
        end
      end
      WAIT_LS: begin
        if (mem_rsp_val) begin
          ls_rsp_val = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_addr    = req.addr;
  assign mem_wen     = req.wen;
  assign mem_wdata   = req.wdata;
  assign mem_wstrb   = req.wstrb;
  assign if_rsp_data = if_rsp_val ? mem_rsp_data : 32'h0;
  assign ls_rsp_data = ls_rsp_val ? mem_rsp_data : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      streak <= 4'd0;
      drop   <= 1'b0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
      drop   <= drop_nxt;
    end
  end

endmodule
